// File: rtl/snn_pkg.sv
// Shared types and default widths for the spiking-neuron datapath blocks.
package snn_pkg;

   localparam int W_W_DEF = 8;
   localparam int D_W_DEF = 8;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      WAIT = 2'd1,
      RDY  = 2'd2
   } slot_state_t;

endpackage

// File: rtl/synapse_dispatch_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag.
module prio_enc #(
   parameter  int N  = 8,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/synapse_dispatch.sv
// Presynaptic event dispatcher: captures spikes, delays them per input in
// timestep ticks, then delivers {weight, spike} to the soma over valid/ready.
module synapse_dispatch
   import snn_pkg::*;
#(
   parameter  int N_PRE  = 8,
   parameter  int W_W    = W_W_DEF,
   parameter  int D_W    = D_W_DEF,
   parameter  int N_SLOT = 8,
   localparam int PA_W   = $clog2(N_PRE),
   localparam int SL_W   = $clog2(N_SLOT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_PRE-1:0] pre_spike,
   input  logic             tick,
   input  logic             cfg_we,
   input  logic [PA_W-1:0]  cfg_addr,
   input  logic [W_W-1:0]   cfg_weight,
   input  logic [D_W-1:0]   cfg_delay,
   output logic             post_valid,
   input  logic             post_ready,
   output logic [W_W-1:0]   post_weight,
   output logic             post_spike,
   output logic             busy,
   output logic [7:0]       drop_cnt
);

   // Delivery handshake: a beat transfers on a posedge where post_valid and
   // post_ready are both 1; until then post_valid/post_weight hold unchanged.

   logic [N_PRE-1:0]  pending;
   logic [W_W-1:0]    tbl_weight [N_PRE];
   logic [D_W-1:0]    tbl_delay  [N_PRE];

   slot_state_t       slot_state     [N_SLOT];
   slot_state_t       slot_state_nxt [N_SLOT];
   logic [D_W-1:0]    slot_rem       [N_SLOT];
   logic [D_W-1:0]    slot_rem_nxt   [N_SLOT];
   logic [W_W-1:0]    slot_weight    [N_SLOT];
   logic [SL_W-1:0]   sel_q;

   logic [N_SLOT-1:0] free_vec, rdy_vec, rdy_avail, hs_mask;
   logic [N_PRE-1:0]  alloc_clear, drop_vec;
   logic [PA_W-1:0]   pend_idx;
   logic [SL_W-1:0]   free_idx, rdy_idx;
   logic              pend_found, free_found, rdy_found;
   logic              alloc, handshake;
   logic [15:0]       drop_sum;
   logic [7:0]        drop_nxt;

   prio_enc #(.N(N_PRE))  u_pend (.req(pending),   .idx(pend_idx), .found(pend_found));
   prio_enc #(.N(N_SLOT)) u_free (.req(free_vec),  .idx(free_idx), .found(free_found));
   prio_enc #(.N(N_SLOT)) u_rdy  (.req(rdy_avail), .idx(rdy_idx),  .found(rdy_found));

   assign handshake  = post_valid & post_ready;
   assign alloc      = pend_found & free_found;
   assign post_spike = post_valid;
   assign busy       = (|pending) | ~(&free_vec);

   always_comb begin
      free_vec    = '0;
      rdy_vec     = '0;
      hs_mask     = '0;
      alloc_clear = '0;
      for (int i = 0; i < N_SLOT; i++) begin
         free_vec[i] = (slot_state[i] == FREE);
         rdy_vec[i]  = (slot_state[i] == RDY);
      end
      if (handshake) hs_mask[sel_q] = 1'b1;
      if (alloc) alloc_clear[pend_idx] = 1'b1;
      // The slot leaving this cycle must not be re-presented on the next beat.
      rdy_avail = rdy_vec & ~hs_mask;
      drop_vec  = pre_spike & pending & ~alloc_clear;
   end

   always_comb begin
      drop_sum = {8'd0, drop_cnt};
      for (int i = 0; i < N_PRE; i++) drop_sum = drop_sum + 16'(drop_vec[i]);
      drop_nxt = (drop_sum > 16'd255) ? 8'hFF : drop_sum[7:0];
   end

   always_comb begin
      for (int i = 0; i < N_SLOT; i++) begin
         slot_state_nxt[i] = slot_state[i];
         slot_rem_nxt[i]   = slot_rem[i];
         case (slot_state[i])
            FREE: if (alloc && free_idx == SL_W'(i)) begin
               slot_state_nxt[i] = (tbl_delay[pend_idx] == '0) ? RDY : WAIT;
               slot_rem_nxt[i]   = tbl_delay[pend_idx];
            end
            WAIT: if (tick && slot_rem[i] != '0) begin
               slot_rem_nxt[i] = slot_rem[i] - 1'b1;
               if (slot_rem[i] == D_W'(1)) slot_state_nxt[i] = RDY;
            end
            RDY:  if (handshake && sel_q == SL_W'(i)) slot_state_nxt[i] = FREE;
            default: slot_state_nxt[i] = FREE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending     <= '0;
         drop_cnt    <= '0;
         post_valid  <= 1'b0;
         post_weight <= '0;
         sel_q       <= '0;
         for (int i = 0; i < N_PRE; i++) begin
            tbl_weight[i] <= '0;
            tbl_delay[i]  <= '0;
         end
         for (int i = 0; i < N_SLOT; i++) begin
            slot_state[i]  <= FREE;
            slot_rem[i]    <= '0;
            slot_weight[i] <= '0;
         end
      end else begin
         pending  <= (pending & ~alloc_clear) | pre_spike;
         drop_cnt <= drop_nxt;
         // Table read for allocation happens on the old contents.
         if (cfg_we) begin
            tbl_weight[cfg_addr] <= cfg_weight;
            tbl_delay[cfg_addr]  <= cfg_delay;
         end
         for (int i = 0; i < N_SLOT; i++) begin
            slot_state[i] <= slot_state_nxt[i];
            slot_rem[i]   <= slot_rem_nxt[i];
         end
         if (alloc) slot_weight[free_idx] <= tbl_weight[pend_idx];
         if (!post_valid || post_ready) begin
            post_valid  <= rdy_found;
            post_weight <= slot_weight[rdy_idx];
            sel_q       <= rdy_idx;
         end
      end
   end

endmodule

// File: tb/tb_synapse_dispatch.sv
// Directed bench for synapse_dispatch with a queue-based delivery scoreboard.
module tb_synapse_dispatch;

   localparam int N_PRE = 8;
   localparam int W_W   = 8;

   logic             clk = 1'b0;
   logic             rst, tick, cfg_we, post_ready;
   logic [N_PRE-1:0] pre_spike;
   logic [2:0]       cfg_addr;
   logic [7:0]       cfg_weight, cfg_delay;
   logic             post_valid, post_spike, busy;
   logic [W_W-1:0]   post_weight;
   logic [7:0]       drop_cnt;

   int               total = 0;
   int               bad   = 0;
   int               beats = 0;
   int               beats_ref;
   logic [W_W-1:0]   exp_q[$];

   synapse_dispatch dut (
      .clk(clk), .rst(rst), .pre_spike(pre_spike), .tick(tick),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_weight(cfg_weight),
      .cfg_delay(cfg_delay), .post_valid(post_valid), .post_ready(post_ready),
      .post_weight(post_weight), .post_spike(post_spike), .busy(busy),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted beat is matched against the expected queue.
   always @(negedge clk) begin
      if (!rst && post_valid && post_ready) begin
         beats++;
         check("beat_spike", 32'(post_spike), 32'd1);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got weight %0h expected no beat", post_weight);
         end else begin
            check("beat_weight", 32'(post_weight), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [7:0] w, input logic [7:0] d);
      cfg_addr = a; cfg_weight = w; cfg_delay = d; cfg_we = 1'b1;
      cyc(1);
      cfg_we = 1'b0;
   endtask

   task automatic spike(input logic [N_PRE-1:0] m);
      pre_spike = m;
      cyc(1);
      pre_spike = '0;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
   endtask

   task automatic wait_beats(input int target, input int budget, input string name);
      int n = 0;
      while (beats < target && n < budget) begin
         cyc(1);
         n++;
      end
      check(name, 32'(beats), 32'(target));
   endtask

   initial begin
      rst = 1'b0; tick = 1'b0; cfg_we = 1'b0; post_ready = 1'b1;
      pre_spike = '0; cfg_addr = '0; cfg_weight = '0; cfg_delay = '0;
      do_reset();
      @(negedge clk);
      check("rst_valid", 32'(post_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);

      // Single event, delay 2 ticks.
      cfg_write(3'd3, 8'h20, 8'd2);
      exp_q.push_back(8'h20);
      spike(8'h08);
      cyc(3);
      check("t1_busy", 32'(busy), 32'd1);
      pulse_tick();
      cyc(3);
      check("t1_no_early", 32'(beats), 32'd0);
      pulse_tick();
      @(negedge clk);
      check("t1_valid_lat0", 32'(post_valid), 32'd0);
      @(negedge clk);
      check("t1_valid_lat1", 32'(post_valid), 32'd1);
      check("t1_weight", 32'(post_weight), 32'h20);
      cyc(2);
      check("t1_beats", 32'(beats), 32'd1);
      check("t1_idle", 32'(busy), 32'd0);

      // Two zero-delay events, lowest input first.
      cfg_write(3'd0, 8'h11, 8'd0);
      cfg_write(3'd5, 8'h55, 8'd0);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h55);
      spike(8'h21);
      wait_beats(3, 20, "t2_beats");
      cyc(2);
      check("t2_idle", 32'(busy), 32'd0);

      // Back-pressure: output held while ready is low.
      post_ready = 1'b0;
      cfg_write(3'd4, 8'h44, 8'd0);
      exp_q.push_back(8'h44);
      spike(8'h10);
      cyc(4);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t3_hold_valid", 32'(post_valid), 32'd1);
         check("t3_hold_weight", 32'(post_weight), 32'h44);
      end
      check("t3_no_beat", 32'(beats), 32'd3);
      @(posedge clk);
      #1;
      post_ready = 1'b1;
      cyc(1);
      check("t3_beat_on_ready", 32'(beats), 32'd4);

      // Full: 8 slots busy, two more events held pending.
      for (int i = 0; i < 8; i++) cfg_write(3'(i), 8'h80 + 8'(i), 8'd10);
      spike(8'hFF);
      cyc(10);
      spike(8'h03);
      cyc(3);
      check("t4_busy", 32'(busy), 32'd1);
      check("t4_no_drop", 32'(drop_cnt), 32'd0);
      for (int i = 0; i < 8; i++) exp_q.push_back(8'h80 + 8'(i));
      exp_q.push_back(8'h80);
      exp_q.push_back(8'h81);
      repeat (9) pulse_tick();
      cyc(3);
      check("t4_no_early", 32'(beats), 32'd4);
      pulse_tick();
      wait_beats(12, 40, "t4_first8");
      cyc(3);
      repeat (9) pulse_tick();
      cyc(3);
      check("t4_no_early2", 32'(beats), 32'd12);
      pulse_tick();
      wait_beats(14, 40, "t4_last2");
      cyc(3);
      check("t4_drop_end", 32'(drop_cnt), 32'd0);
      check("t4_idle", 32'(busy), 32'd0);

      // Drops while all slots are occupied; counter saturates.
      do_reset();
      for (int i = 0; i < 8; i++) cfg_write(3'(i), 8'h01, 8'd100);
      spike(8'hFF);
      cyc(10);
      spike(8'h04);
      spike(8'h04);
      check("t5_drop1", 32'(drop_cnt), 32'd1);
      repeat (253) spike(8'h04);
      check("t5_drop254", 32'(drop_cnt), 32'd254);
      spike(8'h04);
      check("t5_drop255", 32'(drop_cnt), 32'd255);
      repeat (45) spike(8'h04);
      check("t5_drop_sat", 32'(drop_cnt), 32'd255);

      // Reset with three slots waiting discards them.
      do_reset();
      check("t6_drop_clr", 32'(drop_cnt), 32'd0);
      for (int i = 0; i < 3; i++) cfg_write(3'(i), 8'h31 + 8'(i), 8'd3);
      spike(8'h07);
      cyc(6);
      pulse_tick();
      check("t6_busy", 32'(busy), 32'd1);
      beats_ref = beats;
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      @(negedge clk);
      check("t6_valid", 32'(post_valid), 32'd0);
      check("t6_idle", 32'(busy), 32'd0);
      repeat (5) pulse_tick();
      cyc(5);
      check("t6_no_stale", 32'(beats), 32'(beats_ref));

      // Config write racing allocation of the same input.
      cfg_write(3'd1, 8'h10, 8'd0);
      cyc(1);
      exp_q.push_back(8'h10);
      spike(8'h02);
      cfg_write(3'd1, 8'h7F, 8'd0);
      wait_beats(beats_ref + 1, 20, "t7_old");
      exp_q.push_back(8'h7F);
      spike(8'h02);
      wait_beats(beats_ref + 2, 20, "t7_new");
      cyc(2);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
